// File: rtl/instr_mem_loader.sv
// Boot loader: streams a length-prefixed little-endian program image into instruction memory and holds the CPU in reset until loaded.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        reload,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_ready_en;
    logic [15:0] r_len;
    logic [15:0] r_word_idx;
    logic [1:0]  r_lane;
    logic [23:0] r_asm;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_cpu_reset;
    logic        r_done;
    logic        r_error;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_accept;
    logic [15:0] w_len_full;
    logic        w_last_word;
    logic        w_reload_go;

    assign w_accept    = byte_valid && byte_ready;
    assign w_len_full  = {byte_data, r_len[7:0]};
    assign w_last_word = (r_word_idx == (r_len - 16'd1));
    assign w_reload_go = reload && ((r_state == S_DONE) || (r_state == S_ERROR));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_LEN_LO;
        else       r_state <= w_state_next;
    end

    // NOTE: every signal written here gets its default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b0;
        case (r_state)
            S_LEN_LO: begin
                byte_ready = r_ready_en;
                if (w_accept) w_state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                byte_ready = r_ready_en;
                if (w_accept) begin
                    if ({1'b0, w_len_full} > MAX_W)
                        w_state_next = S_ERROR;
                    else if (w_len_full == 16'd0)
`ifdef LOADER_CHECKSUM_EN
                        w_state_next = S_CHECK;
`else
                        w_state_next = S_DONE;
`endif
                    else
                        w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = r_ready_en;
                if (w_accept && (r_lane == 2'd3) && w_last_word)
`ifdef LOADER_CHECKSUM_EN
                    w_state_next = S_CHECK;
`else
                    w_state_next = S_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready = r_ready_en;
                if (w_accept) w_state_next = (byte_data == r_csum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE, S_ERROR: begin
                if (reload) w_state_next = S_LEN_LO;
            end
            default: w_state_next = S_LEN_LO;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ready_en  <= 1'b0;
            r_len       <= 16'd0;
            r_word_idx  <= 16'd0;
            r_lane      <= 2'd0;
            r_asm       <= 24'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE_ADDR;
            r_mem_wdata <= 32'd0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_ready_en  <= 1'b1;
            r_mem_we    <= 1'b0;
            // Status flops track the next state so they flip in the cycle DONE/ERROR is entered or left.
            r_done      <= (w_state_next == S_DONE);
            r_error     <= (w_state_next == S_ERROR);
            r_cpu_reset <= (w_state_next != S_DONE);

            if (w_accept) begin
                case (r_state)
                    S_LEN_LO: r_len[7:0]  <= byte_data;
                    S_LEN_HI: r_len[15:8] <= byte_data;
                    S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ byte_data;
`endif
                        case (r_lane)
                            2'd0: r_asm[7:0]   <= byte_data;
                            2'd1: r_asm[15:8]  <= byte_data;
                            2'd2: r_asm[23:16] <= byte_data;
                            default: begin
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= {byte_data, r_asm};
                                r_mem_addr  <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
                                r_word_idx  <= r_word_idx + 16'd1;
                            end
                        endcase
                        r_lane <= r_lane + 2'd1;
                    end
                    default: ;
                endcase
            end

            if (w_reload_go) begin
                r_len      <= 16'd0;
                r_word_idx <= 16'd0;
                r_lane     <= 2'd0;
                r_asm      <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
                r_csum     <= 8'd0;
`endif
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_reset = r_cpu_reset;
    assign done      = r_done;
    assign error     = r_error;

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Upstream of risc_v_cpu: streams a program image, byte by byte, into instruction memory through the memory's write port.
- Holds the CPU in reset while loading and releases it when the image is complete.
- Replaces hierarchical testbench pokes with a synthesizable boot path fed by a UART/host byte stream.
- Byte order matches test.bin: the first byte received lands at the lowest address (little-endian words).

Parameters:
- MAX_WORDS, 256, capacity of instruction memory in 32-bit words; larger images are rejected.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- byte_valid  input  1  byte_data holds a valid byte
- byte_data  input  8  incoming stream byte
- byte_ready  output  1  loader can accept a byte; transfer occurs when byte_valid && byte_ready
- reload  input  1  single-cycle pulse; restarts loading from DONE or ERROR, ignored in other states
- mem_we  output  1  instruction memory write strobe, one cycle per word
- mem_addr  output  32  byte address of the word being written
- mem_wdata  output  32  word being written
- cpu_reset  output  1  reset to risc_v_cpu; high while not DONE
- done  output  1  image loaded and verified
- error  output  1  image rejected

Behaviour:
- Reset values: state=LEN_LO, byte_ready=0 for the first cycle after reset release (then 1), mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_reset=1, done=0, error=0. All counters clear.
- Stream format:
  - length field N in words, 16-bit little-endian, low byte first;
  - then 4*N payload bytes;
  - then, only when CHECKSUM_EN is defined, one checksum byte.
- States and transitions:
  - LEN_LO: on accept, latch N[7:0] and go to LEN_HI.
  - LEN_HI: on accept, latch N[15:8]. If N > MAX_WORDS, go to ERROR. If N == 0, go to CHECK (with CHECKSUM_EN) or DONE (without). Otherwise go to DATA.
  - DATA: byte_lane counts 0..3. The accepted byte goes to bits [8*lane+7 : 8*lane] of the assembly register. On accepting lane 3:
    - next cycle: mem_we=1, mem_wdata=the assembled word, mem_addr=BASE_ADDR+4*word_idx;
    - word_idx then increments;
    - after word N-1 is written, go to CHECK or DONE.
  - CHECK: described under Optional Feature.
  - DONE: byte_ready=0, done=1, cpu_reset=0. Incoming bytes are not accepted.
  - ERROR: byte_ready=0, error=1, cpu_reset=1.
  - DONE/ERROR on reload=1: go to LEN_LO and clear word_idx, byte_lane, the checksum, done and error. cpu_reset returns to 1 in the same cycle the state leaves DONE.
- Output timing:
  - cpu_reset and done are registered and change in the cycle the state enters or leaves DONE.
  - The final mem_we pulse precedes or coincides with the DONE entry cycle. It never follows the cpu_reset deassertion.
- Write strobes: mem_we is a one-cycle pulse and never asserts outside DATA or the cycle immediately after it. mem_addr and mem_wdata hold their values between writes.
- Stalls: byte_valid low keeps all state. A gap of any length between bytes is legal.
- Address arithmetic: word_idx is 16 bits. mem_addr = BASE_ADDR + (word_idx << 2), modulo 2^32.
- Async reset mid-load: immediate return to reset values. The partially written memory is not cleared.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps an 8-bit XOR of all payload bytes (length bytes excluded).
  - After the payload, the CHECK state accepts one byte.
  - If that byte equals the running XOR, go to DONE; otherwise go to ERROR.
  - For N=0 the expected checksum is 8'h00.
- Undefined: no CHECK state and no checksum logic; the stream ends after the payload.

Test Plan:
- Load N=2 words, bytes 13 05 A0 00 | 93 00 10 00 -> mem_we at 0x0 with 0x00A00513, then at 0x4 with 0x00100093; done=1 and cpu_reset=0 after the second write; byte_ready=0 afterwards.
- Same stream with byte_valid toggled off for 3 cycles between every byte -> identical writes and final state.
- Length field 0x0101 (257 > MAX_WORDS) -> error=1, cpu_reset stays 1, no mem_we pulse.
- N=0 -> done on the cycle after LEN_HI is accepted (with CHECKSUM_EN: after a checksum byte 0x00); no writes.
- Assert reset after 5 payload bytes of N=2 -> outputs return to reset values; a full reload then writes 0x0 and 0x4 correctly. A reload pulse in DONE re-enters LEN_LO with cpu_reset=1.
- With LOADER_CHECKSUM_EN defined, N=1, payload 01 02 03 04: checksum 0x04 -> done; checksum 0x05 -> error, cpu_reset remains 1.
